// File: rtl/mcu_debug_responder.sv
// mcu_debug_responder: services debug-controller requests for a small MCU.
// It handles pause/resume, MCU reset pulses, and register-file and memory
// accesses. Current FSM state is visible on dbg_state.
// Optional build macro: DBG_BYTE_EXTRACT_EN. When it is defined, a memory
// read with a one-hot byte enable returns that byte zero-extended.
//
// Handshake: in_valid is a strobe and there is no ready. A request is
// accepted on any rising edge where in_valid=1 and the FSM is in S_RUN or
// S_PAUSED. Otherwise the command bits are ignored. mcu_busy reports when
// a new request would be dropped.
module mcu_debug_responder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        pause,
  input  logic        resume,
  input  logic        reset_req,
  input  logic        reg_rd,
  input  logic        reg_wr,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [3:0]  mem_be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mcu_busy,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        dbg_err,
  input  logic        mcu_ir_boundary,
  output logic        mcu_stall,
  output logic        mcu_rst,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_wdata,
  output logic        rf_we,
  input  logic [31:0] rf_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be_out,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_RUN      = 4'd0,
    S_PAUSING  = 4'd1,
    S_PAUSED   = 4'd2,
    S_RESUMING = 4'd3,
    S_REG_RD   = 4'd4,
    S_REG_WR   = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_DONE = 4'd7,
    S_MEM_WR   = 4'd8
  } state_t;

  state_t      state_q, state_d;
  logic        stall_q, stall_d;
  logic        rst_pulse_q, rst_pulse_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] rd_word;
  logic        idle;
  logic        busy_accept;

  assign idle = (state_q == S_RUN) || (state_q == S_PAUSED);

`ifdef DBG_BYTE_EXTRACT_EN
  // Reduce a one-hot byte-enabled memory read to its selected byte.
  always_comb begin
    rd_word = mem_rdata;
    case (be_q)
      4'b0001: rd_word = {24'h0, mem_rdata[7:0]};
      4'b0010: rd_word = {24'h0, mem_rdata[15:8]};
      4'b0100: rd_word = {24'h0, mem_rdata[23:16]};
      4'b1000: rd_word = {24'h0, mem_rdata[31:24]};
      default: rd_word = mem_rdata;
    endcase
  end
`else
  assign rd_word = mem_rdata;
`endif

  // Next-state, request decode and port drive.
  always_comb begin
    state_d     = state_q;
    stall_d     = stall_q;
    rst_pulse_d = 1'b0;
    err_d       = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rdata_d     = rdata_q;
    busy_accept = 1'b0;
    rdata_valid = 1'b0;
    rf_addr     = 5'd0;
    rf_wdata    = 32'd0;
    rf_we       = 1'b0;
    mem_addr    = 32'd0;
    mem_wdata   = 32'd0;
    mem_be_out  = 4'd0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    case (state_q)
      S_RUN, S_PAUSED: begin
        if (in_valid) begin
          // Only the highest-priority command bit is acted on.
          if (reset_req) begin
            rst_pulse_d = 1'b1;
          end else if (pause) begin
            if (state_q == S_RUN) state_d = S_PAUSING;
          end else if (resume) begin
            if (state_q == S_PAUSED) begin
              state_d = S_RESUMING;
              stall_d = 1'b0;
            end
          end else if (reg_wr || reg_rd || mem_wr || mem_rd) begin
            if (state_q == S_RUN) begin
              err_d = 1'b1;
            end else begin
              addr_d  = addr;
              wdata_d = wdata;
              be_d    = mem_be;
              if (reg_wr)      state_d = S_REG_WR;
              else if (reg_rd) state_d = S_REG_RD;
              else if (mem_wr) state_d = S_MEM_WR;
              else             state_d = S_MEM_RD;
            end
          end
          busy_accept = (state_d != state_q);
        end
      end
      S_PAUSING: begin
        if (mcu_ir_boundary) begin
          state_d = S_PAUSED;
          stall_d = 1'b1;
        end
      end
      S_RESUMING: state_d = S_RUN;
      S_REG_RD: begin
        rf_addr     = addr_q[4:0];
        rdata_d     = rf_rdata;
        rdata_valid = 1'b1;
        state_d     = S_PAUSED;
      end
      S_REG_WR: begin
        // Register 0 is hard-wired, so its write strobe is never issued.
        rf_addr  = addr_q[4:0];
        rf_wdata = wdata_q;
        rf_we    = (addr_q[4:0] != 5'd0);
        state_d  = S_PAUSED;
      end
      S_MEM_RD: begin
        mem_re     = 1'b1;
        mem_addr   = {addr_q[31:2], 2'b00};
        mem_be_out = be_q;
        state_d    = S_MEM_DONE;
      end
      S_MEM_DONE: begin
        rdata_d     = rd_word;
        rdata_valid = 1'b1;
        state_d     = S_PAUSED;
      end
      S_MEM_WR: begin
        mem_we     = 1'b1;
        mem_addr   = {addr_q[31:2], 2'b00};
        mem_wdata  = wdata_q;
        mem_be_out = be_q;
        state_d    = S_PAUSED;
      end
      default: state_d = S_RUN;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RUN;
      stall_q     <= 1'b0;
      rst_pulse_q <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      rdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      stall_q     <= stall_d;
      rst_pulse_q <= rst_pulse_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rdata_q     <= rdata_d;
    end
  end

  // The read result is visible in the capture cycle itself and held afterwards.
  assign rdata     = rdata_d;
  assign mcu_busy  = !rst && (!idle || busy_accept);
  assign mcu_stall = stall_q;
  assign mcu_rst   = rst_pulse_q;
  assign dbg_err   = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mcu_debug_responder.sv
// Directed bench for mcu_debug_responder with hand-computed expectations.
module tb_mcu_debug_responder;

  localparam logic [3:0] ST_RUN      = 4'd0;
  localparam logic [3:0] ST_PAUSING  = 4'd1;
  localparam logic [3:0] ST_PAUSED   = 4'd2;
  localparam logic [3:0] ST_RESUMING = 4'd3;
  localparam logic [3:0] ST_REG_RD   = 4'd4;
  localparam logic [3:0] ST_MEM_RD   = 4'd6;

`ifdef DBG_BYTE_EXTRACT_EN
  localparam logic [31:0] EXP_MEM_RD = 32'h0000_00BB;
`else
  localparam logic [31:0] EXP_MEM_RD = 32'hAABB_CCDD;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, pause, resume, reset_req, reg_rd, reg_wr, mem_rd, mem_wr;
  logic [3:0]  mem_be;
  logic [31:0] addr, wdata;
  logic        mcu_busy, rdata_valid, dbg_err, mcu_stall, mcu_rst;
  logic [31:0] rdata;
  logic        mcu_ir_boundary;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata, rf_rdata;
  logic        rf_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be_out, dbg_state;
  logic        mem_re, mem_we;

  int n_cmp = 0;
  int n_err = 0;

  mcu_debug_responder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .pause(pause), .resume(resume),
    .reset_req(reset_req), .reg_rd(reg_rd), .reg_wr(reg_wr), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_be(mem_be), .addr(addr), .wdata(wdata),
    .mcu_busy(mcu_busy), .rdata(rdata), .rdata_valid(rdata_valid),
    .dbg_err(dbg_err), .mcu_ir_boundary(mcu_ir_boundary), .mcu_stall(mcu_stall),
    .mcu_rst(mcu_rst), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_we(rf_we),
    .rf_rdata(rf_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be_out(mem_be_out), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // Clock and synchronous-read memory model.
  always #5 clk = ~clk;

  initial mem_rdata = 32'h0;
  always @(posedge clk) mem_rdata <= mem_re ? 32'hAABB_CCDD : 32'h5555_0000;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_cmds();
    in_valid = 0; pause = 0; resume = 0; reset_req = 0;
    reg_rd = 0; reg_wr = 0; mem_rd = 0; mem_wr = 0;
  endtask

  // Advance to the next falling edge; inputs change there, outputs are checked #1 later.
  task automatic next_cyc();
    @(negedge clk);
  endtask

  int busy_cnt;
  int we_seen;

  initial begin
    clear_cmds();
    mem_be = 4'h0; addr = 32'h0; wdata = 32'h0;
    mcu_ir_boundary = 0; rf_rdata = 32'h1234_5678;
    rst = 1;
    #12;
    check_eq("rst_state", {28'h0, dbg_state}, {28'h0, ST_RUN});
    check_eq("rst_busy", {31'h0, mcu_busy}, 32'h0);
    check_eq("rst_stall", {31'h0, mcu_stall}, 32'h0);
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_strobes", {28'h0, mem_re, mem_we, rf_we, mcu_rst}, 32'h0);
    next_cyc();
    rst = 0;
    next_cyc();

    // Pause: boundary low for 3 PAUSING cycles, then high.
    busy_cnt = 0;
    in_valid = 1; pause = 1;
    #1 busy_cnt += int'(mcu_busy);
    for (int i = 0; i < 4; i++) begin
      next_cyc();
      clear_cmds();
      mcu_ir_boundary = (i == 3);
      #1 busy_cnt += int'(mcu_busy);
      if (i == 0) check_eq("pausing_state", {28'h0, dbg_state}, {28'h0, ST_PAUSING});
      if (i == 3) check_eq("pausing_stall", {31'h0, mcu_stall}, 32'h0);
    end
    next_cyc();
    mcu_ir_boundary = 0;
    #1 busy_cnt += int'(mcu_busy);
    check_eq("pause_busy_cycles", busy_cnt, 32'd5);
    check_eq("paused_stall", {31'h0, mcu_stall}, 32'h1);
    check_eq("paused_state", {28'h0, dbg_state}, {28'h0, ST_PAUSED});

    // Pause while paused is a no-op.
    in_valid = 1; pause = 1;
    #1 check_eq("pause_noop_busy", {31'h0, mcu_busy}, 32'h0);
    next_cyc();
    clear_cmds();
    #1 check_eq("pause_noop_state", {28'h0, dbg_state}, {28'h0, ST_PAUSED});

    // Register read.
    in_valid = 1; reg_rd = 1; addr = 32'd5;
    next_cyc();
    clear_cmds(); addr = 32'hFFFF_FFFF;
    #1;
    check_eq("regrd_state", {28'h0, dbg_state}, {28'h0, ST_REG_RD});
    check_eq("regrd_addr", {27'h0, rf_addr}, 32'd5);
    check_eq("regrd_valid", {31'h0, rdata_valid}, 32'h1);
    check_eq("regrd_rdata", rdata, 32'h1234_5678);
    next_cyc();
    rf_rdata = 32'hCAFE_0000;
    #1;
    check_eq("regrd_valid_end", {31'h0, rdata_valid}, 32'h0);
    check_eq("regrd_rdata_hold", rdata, 32'h1234_5678);

    // Register write to index 0: no strobe.
    we_seen = 0;
    in_valid = 1; reg_wr = 1; addr = 32'h20; wdata = 32'h1111_2222;
    for (int i = 0; i < 3; i++) begin
      next_cyc();
      clear_cmds();
      #1 we_seen += int'(rf_we);
    end
    check_eq("regwr0_no_we", we_seen, 32'd0);

    // Register write to index 3.
    in_valid = 1; reg_wr = 1; addr = 32'h3; wdata = 32'h9ABC_DEF0;
    next_cyc();
    clear_cmds(); wdata = 32'h0;
    #1;
    check_eq("regwr3_we", {31'h0, rf_we}, 32'h1);
    check_eq("regwr3_addr", {27'h0, rf_addr}, 32'd3);
    check_eq("regwr3_data", rf_wdata, 32'h9ABC_DEF0);
    next_cyc();
    #1 check_eq("regwr3_we_end", {31'h0, rf_we}, 32'h0);

    // Memory read.
    in_valid = 1; mem_rd = 1; addr = 32'h102; mem_be = 4'b0100;
    next_cyc();
    clear_cmds(); mem_be = 4'h0;
    #1;
    check_eq("memrd_re", {31'h0, mem_re}, 32'h1);
    check_eq("memrd_addr", mem_addr, 32'h100);
    check_eq("memrd_be", {28'h0, mem_be_out}, 32'h4);
    check_eq("memrd_busy", {31'h0, mcu_busy}, 32'h1);
    next_cyc();
    #1;
    check_eq("memrd_rdata", rdata, EXP_MEM_RD);
    check_eq("memrd_valid", {31'h0, rdata_valid}, 32'h1);
    check_eq("memrd_re_end", {31'h0, mem_re}, 32'h0);
    next_cyc();
    #1;
    check_eq("memrd_hold", rdata, EXP_MEM_RD);
    check_eq("memrd_state_end", {28'h0, dbg_state}, {28'h0, ST_PAUSED});

    // Memory write.
    in_valid = 1; mem_wr = 1; addr = 32'h203; wdata = 32'h0BAD_F00D; mem_be = 4'b0011;
    next_cyc();
    clear_cmds();
    #1;
    check_eq("memwr_we", {31'h0, mem_we}, 32'h1);
    check_eq("memwr_addr", mem_addr, 32'h200);
    check_eq("memwr_data", mem_wdata, 32'h0BAD_F00D);
    check_eq("memwr_be", {28'h0, mem_be_out}, 32'h3);
    next_cyc();

    // Resume.
    in_valid = 1; resume = 1;
    #1 check_eq("resume_busy", {31'h0, mcu_busy}, 32'h1);
    next_cyc();
    clear_cmds();
    #1;
    check_eq("resuming_state", {28'h0, dbg_state}, {28'h0, ST_RESUMING});
    check_eq("resuming_stall", {31'h0, mcu_stall}, 32'h0);
    next_cyc();
    #1 check_eq("resumed_state", {28'h0, dbg_state}, {28'h0, ST_RUN});

    // Memory write while running is rejected.
    in_valid = 1; mem_wr = 1; addr = 32'h40; wdata = 32'h7777_7777; mem_be = 4'hF;
    #1 check_eq("reject_busy", {31'h0, mcu_busy}, 32'h0);
    next_cyc();
    clear_cmds();
    #1;
    check_eq("reject_err", {31'h0, dbg_err}, 32'h1);
    check_eq("reject_we", {31'h0, mem_we}, 32'h0);
    check_eq("reject_state", {28'h0, dbg_state}, {28'h0, ST_RUN});
    check_eq("reject_rdata", rdata, EXP_MEM_RD);
    next_cyc();
    #1 check_eq("reject_err_end", {31'h0, dbg_err}, 32'h0);

    // Pause and reset_req together: only the reset pulse.
    in_valid = 1; pause = 1; reset_req = 1;
    next_cyc();
    clear_cmds();
    #1;
    check_eq("rstreq_pulse", {31'h0, mcu_rst}, 32'h1);
    check_eq("rstreq_state", {28'h0, dbg_state}, {28'h0, ST_RUN});
    check_eq("rstreq_stall", {31'h0, mcu_stall}, 32'h0);
    next_cyc();
    #1;
    check_eq("rstreq_pulse_end", {31'h0, mcu_rst}, 32'h0);
    check_eq("rstreq_stall_end", {31'h0, mcu_stall}, 32'h0);

    // Pause again (boundary already high), then reset in the middle of a memory read.
    mcu_ir_boundary = 1;
    in_valid = 1; pause = 1;
    next_cyc();
    clear_cmds();
    next_cyc();
    mcu_ir_boundary = 0;
    #1 check_eq("repause_state", {28'h0, dbg_state}, {28'h0, ST_PAUSED});
    in_valid = 1; mem_rd = 1; addr = 32'h10; mem_be = 4'hF;
    next_cyc();
    clear_cmds();
    #1 check_eq("midrd_state", {28'h0, dbg_state}, {28'h0, ST_MEM_RD});
    rst = 1;
    #1;
    check_eq("midrd_rst_re", {31'h0, mem_re}, 32'h0);
    check_eq("midrd_rst_busy", {31'h0, mcu_busy}, 32'h0);
    check_eq("midrd_rst_rdata", rdata, 32'h0);
    next_cyc();
    rst = 0;
    next_cyc();
    #1;
    check_eq("post_rst_state", {28'h0, dbg_state}, {28'h0, ST_RUN});
    check_eq("post_rst_stall", {31'h0, mcu_stall}, 32'h0);
    check_eq("post_rst_strobes", {29'h0, mem_we, rf_we, rdata_valid}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
